// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared definitions for the synchronous FIFO controller: read-mode constants
// and a constant-evaluable ceil(log2) used to size pointers and the count.
package sync_fifo_ctrl_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Smallest r with 2**r >= value; usable in parameter and port-width expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_sdp_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with
// enable and synchronous output reset, shaped for block RAM inference.
// Ports: clk, rst (clears the read register only), we/waddr/wdata (write),
//        re/raddr (read request), rdata (registered read data).
module sdp_ram #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned WORDS = 2 ** AW;

  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] rdata_q;

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Parametrised single-clock FIFO controller with standard or first-word-fall-
// through read mode, programmable almost-full/almost-empty thresholds, exact
// occupancy count and sticky overflow/underflow flags.
// Ports: clk, rst (sync, active-high); wr_en/wr_data write side;
//        rd_en (read request / FWFT pop), rd_data, rd_valid read side;
//        full, empty, almost_full, almost_empty, count status;
//        overflow, underflow sticky errors cleared by err_clr.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned DEPTH    = 2048,
  parameter int unsigned FWFT     = FIFO_STD,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int unsigned AW      = clog2(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam bit          IS_FWFT = (FWFT == FIFO_FWFT);

  // Reject illegal configurations at elaboration.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (AE_LEVEL >= AF_LEVEL) ||
      ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT))) begin : g_param_check
    $fatal(1, "sync_fifo_ctrl: illegal DEPTH/FWFT/AE_LEVEL/AF_LEVEL combination");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          std_valid_q, std_valid_d;
  logic          out_valid_q, out_valid_d;  // FWFT output register occupied
  logic          ram_vld_q, ram_vld_d;      // FWFT: RAM read register holds an unconsumed word
  logic [DW-1:0] out_data_q, out_data_d;

  logic [DW-1:0] ram_rdata;
  logic          full_c, empty_c, wr_acc, rd_acc, ram_re, load_out;
  logic [CW-1:0] mem_cnt;

  sdp_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Handshake decode and FWFT prefetch control.
  always_comb begin
    full_c   = (count_q == CW'(DEPTH));
    empty_c  = IS_FWFT ? !out_valid_q : (count_q == '0);
    wr_acc   = wr_en && !full_c;
    rd_acc   = rd_en && !empty_c;
    // Words still sitting in the array, not yet pulled into the prefetch stages.
    mem_cnt  = count_q - CW'(out_valid_q) - CW'(ram_vld_q);
    load_out = IS_FWFT && ram_vld_q && (!out_valid_q || rd_acc);
    // In FWFT mode the array is read whenever the RAM stage is free or draining.
    ram_re   = IS_FWFT ? ((mem_cnt != '0) && (!ram_vld_q || load_out)) : rd_acc;
  end

  // Next-state computation.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d    = rd_ptr_q + AW'(ram_re);
    count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
    std_valid_d = !IS_FWFT && rd_acc;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ram_vld_d   = ram_vld_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;

    if (IS_FWFT) begin
      if (load_out) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_rdata;
      end else if (rd_acc) begin
        out_valid_d = 1'b0;
      end
      if (ram_re)        ram_vld_d = 1'b1;
      else if (load_out) ram_vld_d = 1'b0;
    end

    // A new error in the same cycle as err_clr wins.
    if (err_clr)          ovf_d = 1'b0;
    if (wr_en && full_c)  ovf_d = 1'b1;
    if (err_clr)          udf_d = 1'b0;
    if (rd_en && empty_c) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      std_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      ram_vld_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      std_valid_q <= std_valid_d;
      out_valid_q <= out_valid_d;
      ram_vld_q   <= ram_vld_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rd_data      = IS_FWFT ? out_data_q : ram_rdata;
  assign rd_valid     = IS_FWFT ? out_valid_q : std_valid_q;
  assign full         = full_c;
  assign empty        = empty_c;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: one standard-mode and one FWFT instance (DEPTH=8,
// AF_LEVEL=6, AE_LEVEL=2), directed steps followed by random traffic, each
// cycle compared against a queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Standard-mode instance signals
  logic          s_rst, s_wr_en, s_rd_en, s_err_clr;
  logic [DW-1:0] s_wr_data, s_rd_data;
  logic          s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [3:0]    s_count;

  // FWFT instance signals
  logic          f_rst, f_wr_en, f_rd_en, f_err_clr;
  logic [DW-1:0] f_wr_data, f_rd_data;
  logic          f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0]    f_count;

  sync_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf),
    .underflow(s_udf), .err_clr(s_err_clr));

  sync_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_udf), .err_clr(f_err_clr));

  // Standard-mode model: contents queue, last read word, sticky flags.
  logic [DW-1:0] sq[$];
  logic [DW-1:0] sm_data;
  logic          sm_valid, sm_ovf, sm_udf;

  // FWFT model: contents queue, write edge of each word, edge at which the
  // head word is first presented, edge counter.
  logic [DW-1:0] fq[$];
  int            fw[$];
  int            fhead_e;
  int            fcyc;
  logic [DW-1:0] fm_data;
  logic          fm_ovf, fm_udf;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic s_step(input logic we, input logic [DW-1:0] wd, input logic re,
                        input logic clr, input logic rs);
    logic mfull, memp;
    s_wr_en = we; s_wr_data = wd; s_rd_en = re; s_err_clr = clr; s_rst = rs;
    @(posedge clk);
    mfull = (sq.size() == DEPTH);
    memp  = (sq.size() == 0);
    if (rs) begin
      sq.delete();
      sm_data = '0; sm_valid = 1'b0; sm_ovf = 1'b0; sm_udf = 1'b0;
    end else begin
      sm_valid = re && !memp;
      if (sm_valid) sm_data = sq.pop_front();
      if (we && !mfull) sq.push_back(wd);
      if (clr) sm_ovf = 1'b0;
      if (we && mfull) sm_ovf = 1'b1;
      if (clr) sm_udf = 1'b0;
      if (re && memp) sm_udf = 1'b1;
    end
    #1;
    chk("s_count",    32'(s_count),    32'(sq.size()));
    chk("s_full",     32'(s_full),     32'(sq.size() == DEPTH));
    chk("s_empty",    32'(s_empty),    32'(sq.size() == 0));
    chk("s_af",       32'(s_af),       32'(sq.size() >= AF));
    chk("s_ae",       32'(s_ae),       32'(sq.size() <= AE));
    chk("s_overflow", 32'(s_ovf),      32'(sm_ovf));
    chk("s_underflow",32'(s_udf),      32'(sm_udf));
    chk("s_rd_valid", 32'(s_rd_valid), 32'(sm_valid));
    chk("s_rd_data",  32'(s_rd_data),  32'(sm_data));
  endtask

  task automatic f_step(input logic we, input logic [DW-1:0] wd, input logic re,
                        input logic clr, input logic rs);
    logic mfull, vis, pop, push, was_empty, shown;
    int   old_e;
    f_wr_en = we; f_wr_data = wd; f_rd_en = re; f_err_clr = clr; f_rst = rs;
    @(posedge clk);
    fcyc++;
    if (rs) begin
      fq.delete(); fw.delete();
      fhead_e = 0; fm_data = '0; fm_ovf = 1'b0; fm_udf = 1'b0;
    end else begin
      mfull     = (fq.size() == DEPTH);
      vis       = (fq.size() > 0) && (fhead_e < fcyc);
      pop       = re && vis;
      push      = we && !mfull;
      was_empty = (fq.size() == 0);
      old_e     = fhead_e;
      if (push) begin fq.push_back(wd); fw.push_back(fcyc); end
      if (pop) begin
        void'(fq.pop_front()); void'(fw.pop_front());
        // Next word: fetched once written and the previous one has moved on,
        // presented no earlier than the pop that frees the output.
        if (fq.size() > 0) fhead_e = imax(imax(fw[0] + 1, old_e) + 1, fcyc);
      end else if (push && was_empty) begin
        fhead_e = fcyc + 2;
      end
      if (clr) fm_ovf = 1'b0;
      if (we && mfull) fm_ovf = 1'b1;
      if (clr) fm_udf = 1'b0;
      if (re && !vis) fm_udf = 1'b1;
    end
    shown = (fq.size() > 0) && (fhead_e <= fcyc);
    if (shown) fm_data = fq[0];
    #1;
    chk("f_count",    32'(f_count),    32'(fq.size()));
    chk("f_full",     32'(f_full),     32'(fq.size() == DEPTH));
    chk("f_empty",    32'(f_empty),    32'(!shown));
    chk("f_rd_valid", 32'(f_rd_valid), 32'(shown));
    chk("f_af",       32'(f_af),       32'(fq.size() >= AF));
    chk("f_ae",       32'(f_ae),       32'(fq.size() <= AE));
    chk("f_overflow", 32'(f_ovf),      32'(fm_ovf));
    chk("f_underflow",32'(f_udf),      32'(fm_udf));
    chk("f_rd_data",  32'(f_rd_data),  32'(fm_data));
  endtask

  initial begin
    fcyc = 0;
    f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0; f_wr_data = '0;

    // Reset state
    s_step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", 32'(s_empty), 32'd1);

    // Fill 0x11..0x18, overflow on 9th write, drain in order
    for (int i = 0; i < 8; i++) s_step(1'b1, DW'(16'h11 + i), 1'b0, 1'b0, 1'b0);
    chk("t1_full", 32'(s_full), 32'd1);
    chk("t1_count", 32'(s_count), 32'd8);
    s_step(1'b1, 16'h0099, 1'b0, 1'b0, 1'b0);
    chk("t1_ovf", 32'(s_ovf), 32'd1);
    chk("t1_count9", 32'(s_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      s_step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t1_rd", 32'(s_rd_data), 32'(16'h11 + i));
    end
    s_step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Interleaved traffic across two pointer wraps
    s_step(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) s_step(1'b1, DW'(16'h0100 + i), 1'b1, 1'b0, 1'b0);
    s_step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t2_last", 32'(s_rd_data), 32'h0113);
    chk("t2_ovf", 32'(s_ovf), 32'd0);

    // Full with simultaneous read/write, then empty with simultaneous read/write
    for (int i = 0; i < 8; i++) s_step(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
    s_step(1'b1, 16'h02AA, 1'b1, 1'b0, 1'b0);
    chk("t3_count", 32'(s_count), 32'd7);
    chk("t3_oldest", 32'(s_rd_data), 32'h0200);
    for (int i = 0; i < 7; i++) s_step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    s_step(1'b1, 16'h05A5, 1'b1, 1'b0, 1'b0);
    chk("t3_count1", 32'(s_count), 32'd1);
    chk("t3_udf", 32'(s_udf), 32'd1);
    s_step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Threshold sweep 0->8->0
    s_step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) s_step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) s_step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation with count=5 and overflow set
    for (int i = 0; i < 9; i++) s_step(1'b1, DW'(16'h0300 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) s_step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t6_pre", 32'(s_count), 32'd5);
    s_step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t6_count", 32'(s_count), 32'd0);
    chk("t6_ovf", 32'(s_ovf), 32'd0);
    s_step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t6_clr", 32'(s_ovf | s_udf), 32'd0);

    // Random standard-mode traffic
    for (int i = 0; i < 300; i++)
      s_step(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 50),
             1'($urandom_range(0, 15) == 0), 1'b0);
    s_step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // FWFT: first-word latency and back-to-back pops
    f_step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    f_step(1'b1, 16'h00AB, 1'b0, 1'b0, 1'b0);
    chk("t4_n0", 32'(f_empty), 32'd1);
    f_step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t4_n1", 32'(f_empty), 32'd1);
    f_step(1'b1, 16'h00AC, 1'b0, 1'b0, 1'b0);
    chk("t4_n2_empty", 32'(f_empty), 32'd0);
    chk("t4_n2_data", 32'(f_rd_data), 32'h00AB);
    f_step(1'b1, 16'h00AD, 1'b0, 1'b0, 1'b0);
    f_step(1'b1, 16'h00AE, 1'b0, 1'b0, 1'b0);
    f_step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    f_step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      f_step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t4_nobubble", 32'({f_rd_valid, f_rd_data}), 32'({1'b1, 16'(16'h00AC + i)}));
    end
    f_step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t4_drained", 32'(f_empty), 32'd1);

    // Random FWFT traffic
    for (int i = 0; i < 300; i++)
      f_step(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 55),
             1'($urandom_range(0, 15) == 0), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
